// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, queue entry layout and
// the HALT opcode test.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_DROP   = 2'd2,
      ST_HALTED = 2'd3
   } fetchState_e;

   localparam logic [4:0]  HALT_OPC    = 5'b00000;
   localparam logic [15:0] DEFAULT_NOP = 16'h0800;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pcPlus2;
      logic        alignErr;
   } fetchEntry_t;

   localparam int ENTRY_W = $bits(fetchEntry_t);

   function automatic logic isHalt(input logic [15:0] word);
      return word[15:11] == HALT_OPC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched entries until decode takes them.
// Clear wins over push/pop; a push into a full queue is accepted only with a pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = ENTRY_W
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_clear,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_pushData,
   input  logic                         i_pop,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic [WIDTH-1:0]             o_head
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rdPtr;
   logic [PW-1:0]    r_wrPtr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_doPush;
   logic             w_doPop;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
   endfunction

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_doPop  = i_pop & (r_count != '0);
   assign w_doPush = i_push & (~w_full | w_doPop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
         if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the count decides what is visible.
   always_ff @(posedge i_clk) begin
      if (w_doPush && !i_clear) r_mem[r_wrPtr] <= i_pushData;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, single-outstanding instruction memory reads, entry queue to decode.
// Optional FETCH_ALIGN_CHK_EN turns odd PCs into queued alignment faults instead of masking bit 0.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          QDEPTH    = 2,
   parameter logic [15:0] NOP_INSTR = DEFAULT_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        dec_ready,
   output logic        valid,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2,
   output logic        align_err,
   output logic        halted,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic        imem_done,
   input  logic        imem_stall
);

   localparam int CW = $clog2(QDEPTH + 1);

`ifdef FETCH_ALIGN_CHK_EN
   localparam logic [15:0] PC_MASK = 16'hFFFF;
`else
   localparam logic [15:0] PC_MASK = 16'hFFFE;
`endif

   fetchState_e        r_state;
   fetchState_e        w_nextState;
   logic [15:0]        r_pc;
   logic [15:0]        r_pcReq;
   logic [CW-1:0]      w_count;
   logic [ENTRY_W-1:0] w_headBits;
   fetchEntry_t        w_head;
   fetchEntry_t        w_pushEntry;
   logic               w_push;
   logic               w_pop;
   logic               w_room;
   logic               w_alignFault;
   logic               w_issue;

`ifdef FETCH_ALIGN_CHK_EN
   assign w_alignFault = r_pc[0];
`else
   assign w_alignFault = 1'b0;
`endif

   assign w_room  = (w_count < CW'(QDEPTH));
   assign w_issue = (r_state == ST_IDLE) & ~redirect & ~imem_stall & w_room & ~w_alignFault;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc    <= RESET_PC & PC_MASK;
         r_pcReq <= '0;
      end else if (redirect) begin
         r_pc    <= redirect_pc & PC_MASK;
      end else if (w_issue) begin
         r_pcReq <= r_pc;
         r_pc    <= r_pc + 16'd2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_nextState;
   end

   // A redirect overrides everything; a response already in flight must be
   // swallowed in DROP unless it lands in the same cycle as the redirect.
   always_comb begin
      w_nextState = r_state;
      w_push      = 1'b0;
      w_pushEntry = '{instr: imem_data, pcPlus2: r_pcReq + 16'd2, alignErr: 1'b0};
      if (redirect) begin
         case (r_state)
            ST_WAIT: w_nextState = imem_done ? ST_IDLE : ST_DROP;
            ST_DROP: w_nextState = ST_DROP;
            default: w_nextState = ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_alignFault && w_room) begin
                  w_push      = 1'b1;
                  w_pushEntry = '{instr: 16'h0000, pcPlus2: r_pc + 16'd2, alignErr: 1'b1};
                  w_nextState = ST_HALTED;
               end else if (w_issue) begin
                  w_nextState = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_done) begin
                  w_push      = 1'b1;
                  w_nextState = isHalt(imem_data) ? ST_HALTED : ST_IDLE;
               end
            end
            ST_DROP: begin
               if (imem_done) w_nextState = ST_IDLE;
            end
            ST_HALTED: w_nextState = ST_HALTED;
         endcase
      end
   end

   assign w_pop = valid & dec_ready;

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (ENTRY_W)
   ) u_queue (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .i_clear    (redirect),
      .i_push     (w_push),
      .i_pushData (w_pushEntry),
      .i_pop      (w_pop),
      .o_count    (w_count),
      .o_head     (w_headBits)
   );

   assign w_head    = fetchEntry_t'(w_headBits);
   assign valid     = (w_count != '0);
   assign instr     = valid ? w_head.instr   : NOP_INSTR;
   assign pc_plus2  = valid ? w_head.pcPlus2 : 16'h0000;
   assign align_err = valid & w_head.alignErr;
   assign halted    = (r_state == ST_HALTED);
   assign imem_rd   = w_issue;
   assign imem_addr = r_pc;

endmodule
